fib_regfile_alu: RTL and testbench

//  Datapath stage directly downstream of the address/write-enable sequencer.

---
 rtl/fib_regfile_alu.sv | 77 +++++++
 tb/tb_fib_regfile_alu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fib_regfile_alu.sv
// Register file with two combinational read ports, one write port and a registered adder
// stage, used by the upstream sequencer to build a recurrence in place.
module fib_regfile_alu #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wer,
    input  logic          wea,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    input  logic          init_sel,
    input  logic [DW-1:0] init_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] sum_q,
    output logic          ovf,
    output logic [AW:0]   wr_cnt
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] CNT_MAX = '1;

    logic [DW-1:0] rf [DEPTH];
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] wdata;
    logic [DW:0]   sum_full;

    // Reads see the pre-edge contents, so a same-cycle write never bypasses to a/b.
    assign a        = rf[addr1];
    assign b        = rf[addr2];
    assign sum_full = {1'b0, a} + {1'b0, b};
    assign wdata    = init_sel ? init_data : sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wer) begin
            rf[addr3] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            ovf   <= 1'b0;
        end else if (wea) begin
            sum_q <= sum_full[DW-1:0];
            if (sum_full[DW]) begin
                ovf <= 1'b1;
            end
        end
    end

    // Debug read samples the old entry when it is being overwritten on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rf[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (wer && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fib_regfile_alu.sv
// Directed self-checking bench for fib_regfile_alu: a 32-bit instance for the main
// sequences and an 8-bit instance for carry-out behaviour.
module tb_fib_regfile_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        wer, wea, init_sel;
    logic [5:0]  addr1, addr2, addr3, rd_addr;
    logic [31:0] init_data;
    logic [31:0] rd_data, sum_q;
    logic        ovf;
    logic [6:0]  wr_cnt;

    logic        wer8, wea8, init_sel8;
    logic [5:0]  addr1_8, addr2_8, addr3_8, rd_addr8;
    logic [7:0]  init_data8;
    logic [7:0]  rd_data8, sum_q8;
    logic        ovf8;
    logic [6:0]  wr_cnt8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fib_regfile_alu #(.DW(32), .AW(6)) dut (
        .clk(clk), .rst(rst), .wer(wer), .wea(wea),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .init_sel(init_sel), .init_data(init_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .sum_q(sum_q), .ovf(ovf), .wr_cnt(wr_cnt)
    );

    fib_regfile_alu #(.DW(8), .AW(6)) dut8 (
        .clk(clk), .rst(rst), .wer(wer8), .wea(wea8),
        .addr1(addr1_8), .addr2(addr2_8), .addr3(addr3_8),
        .init_sel(init_sel8), .init_data(init_data8), .rd_addr(rd_addr8),
        .rd_data(rd_data8), .sum_q(sum_q8), .ovf(ovf8), .wr_cnt(wr_cnt8)
    );

    // Drive the 32-bit instance, then advance one edge and settle 1ns past it.
    task automatic applyStimulus(input logic w_r, input logic w_a, input logic sel,
                                 input logic [5:0] a1, input logic [5:0] a2,
                                 input logic [5:0] a3, input logic [31:0] data,
                                 input logic [5:0] rda);
        wer = w_r; wea = w_a; init_sel = sel;
        addr1 = a1; addr2 = a2; addr3 = a3;
        init_data = data; rd_addr = rda;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic idle8();
        wer8 = 0; wea8 = 0; init_sel8 = 0;
        addr1_8 = 0; addr2_8 = 0; addr3_8 = 0; rd_addr8 = 0; init_data8 = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle8();
        wer = 0; wea = 0; init_sel = 0;
        addr1 = 0; addr2 = 0; addr3 = 0; rd_addr = 0; init_data = 0;
        #1;
        checkOutput("por_sum_q", sum_q, 0);
        checkOutput("por_ovf", ovf, 0);
        checkOutput("por_wr_cnt", wr_cnt, 0);
        checkOutput("por_ovf8", ovf8, 0);
        @(negedge clk);
        rst = 1'b0;

        // Random writes and adds, then a reset pulse away from any edge.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 1, 6'($urandom), 6'($urandom), 6'($urandom),
                          $urandom | 32'h8000_0000, 6'($urandom));
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_sum_q", sum_q, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_wr_cnt", wr_cnt, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 64; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 6'(a));
            checkOutput($sformatf("rst_rf%0d", a), rd_data, 0);
        end

        // Seed values.
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0, 1, 1, 0);
        checkOutput("seed_wr_cnt", wr_cnt, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("seed_rf0", rd_data, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("seed_rf1", rd_data, 1);

        // Fibonacci build: rf[n] = F(n+1).
        for (int i = 0; i <= 27; i++) begin
            applyStimulus(0, 1, 0, 6'(i), 6'(i + 1), 0, 0, 0);
            if (i == 0) checkOutput("fib_first_sum", sum_q, 2);
            applyStimulus(1, 0, 0, 0, 0, 6'(i + 2), 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 29);
        checkOutput("fib_rf29", rd_data, 832040);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 10);
        checkOutput("fib_rf10", rd_data, 89);
        checkOutput("fib_ovf", ovf, 0);
        checkOutput("fib_wr_cnt", wr_cnt, 30);

        // Same-edge write and add on the same address.
        applyStimulus(1, 0, 1, 0, 0, 5, 7, 0);
        applyStimulus(1, 0, 1, 0, 0, 6, 1, 0);
        applyStimulus(1, 0, 1, 0, 0, 7, 2, 0);
        applyStimulus(0, 1, 0, 6, 7, 0, 0, 0);
        checkOutput("hz_sum_pre", sum_q, 3);
        applyStimulus(1, 1, 0, 5, 6, 5, 0, 5);
        checkOutput("hz_sum_old", sum_q, 8);
        checkOutput("hz_rd_old", rd_data, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
        checkOutput("hz_rd_new", rd_data, 3);
        checkOutput("hz_wr_cnt", wr_cnt, 34);

        // 8-bit carry out and sticky overflow.
        wer8 = 1; init_sel8 = 1; addr3_8 = 0; init_data8 = 200;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        addr3_8 = 1; init_data8 = 100;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        idle8(); wea8 = 1; addr1_8 = 0; addr2_8 = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("dw8_sum", sum_q8, 44);
        checkOutput("dw8_ovf", ovf8, 1);
        idle8(); wer8 = 1; init_sel8 = 1; addr3_8 = 2; init_data8 = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        idle8(); wea8 = 1; addr1_8 = 1; addr2_8 = 2;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("dw8_sum_nc", sum_q8, 101);
        checkOutput("dw8_ovf_sticky", ovf8, 1);
        idle8();

        // Reset in the middle of the build loop, coincident with a pending write.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 6'(i), 6'(i + 1), 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0, 6'(i + 2), 0, 0);
        end
        applyStimulus(0, 1, 0, 10, 11, 0, 0, 0);
        wer = 1; wea = 1; addr3 = 12; rd_addr = 12;
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_sum_q", sum_q, 0);
        checkOutput("mid_wr_cnt", wr_cnt, 0);
        checkOutput("mid_ovf8", ovf8, 0);
        @(posedge clk);
        #1;
        checkOutput("mid_hold_wr_cnt", wr_cnt, 0);
        checkOutput("mid_hold_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("mid_rf12", rd_data, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("mid_rf1", rd_data, 0);
        applyStimulus(1, 0, 1, 0, 0, 3, 9, 0);
        checkOutput("mid_restart_cnt", wr_cnt, 1);

        // Address wrap and write-counter saturation.
        for (int i = 0; i < 130; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 6'(i), 32'(i), 0);
        end
        checkOutput("sat_wr_cnt", wr_cnt, 127);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("wrap_rf1", rd_data, 129);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 63);
        checkOutput("wrap_rf63", rd_data, 127);
        checkOutput("sat_hold", wr_cnt, 127);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
